mm_ss_timer_counter: RTL and testbench



---
 rtl/mm_ss_timer_counter.sv | 237 +++++++++++++++++++++++
 tb/tb_mm_ss_timer_counter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mm_ss_timer_counter.sv
// mm_ss_timer_counter
// Four-digit BCD MM:SS counter at the heart of the stopwatch/countdown timer.
// Counts up or down on a 1 Hz tick, supports run/pause, preset loading with
// digit clamping, and signals expiry with a one-cycle done pulse.

module mm_ss_timer_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       mode,
    input  logic       start,
    input  logic       load,
    input  logic [7:0] preset_min,
    input  logic [7:0] preset_sec,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic       running,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSE   = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    state_t     state;
    logic       mode_q;

    // Digit registers: seconds units/tens, minutes units/tens
    logic [3:0] su;
    logic [3:0] st;
    logic [3:0] mu;
    logic [3:0] mt;

    // Clamped preset digits
    logic [3:0] ld_su;
    logic [3:0] ld_st;
    logic [3:0] ld_mu;
    logic [3:0] ld_mt;

    // Incremented digits and carries
    logic [3:0] up_su;
    logic [3:0] up_st;
    logic [3:0] up_mu;
    logic [3:0] up_mt;
    logic       up_c0;
    logic       up_c1;
    logic       up_c2;

    // Decremented digits and borrows
    logic [4:0] su_d;
    logic [4:0] st_d;
    logic [4:0] mu_d;
    logic [4:0] mt_d;
    logic [3:0] dn_su;
    logic [3:0] dn_st;
    logic [3:0] dn_mu;
    logic [3:0] dn_mt;
    logic       dn_b0;
    logic       dn_b1;
    logic       dn_b2;

    // Terminal-value flags for current and next values
    logic       at_max;
    logic       at_zero;
    logic       up_hits_max;
    logic       dn_hits_zero;

    // Digit minus one as x + ~1 + 1; bit 4 is the carry-out, 0 means borrow.
    function automatic logic [4:0] dec_digit(input logic [3:0] x);
        logic [4:0] sum;
        sum = {1'b0, x} + {1'b0, ~4'd1} + 5'd1;
        return sum;
    endfunction

    // Preset digits limited to legal BCD ranges before they reach the counter
    always_comb begin
        ld_su = (preset_sec[3:0] > 4'd9) ? 4'd9 : preset_sec[3:0];
        ld_st = (preset_sec[7:4] > 4'd5) ? 4'd5 : preset_sec[7:4];
        ld_mu = (preset_min[3:0] > 4'd9) ? 4'd9 : preset_min[3:0];
        ld_mt = (preset_min[7:4] > 4'd9) ? 4'd9 : preset_min[7:4];
    end

    // Up-count ripple: each digit advances only when every lower digit wraps
    always_comb begin
        up_c0 = (su == 4'd9);
        up_su = up_c0 ? 4'd0 : su + 4'd1;

        up_c1 = up_c0 && (st == 4'd5);
        if (up_c0) begin
            up_st = (st == 4'd5) ? 4'd0 : st + 4'd1;
        end else begin
            up_st = st;
        end

        up_c2 = up_c1 && (mu == 4'd9);
        if (up_c1) begin
            up_mu = (mu == 4'd9) ? 4'd0 : mu + 4'd1;
        end else begin
            up_mu = mu;
        end

        if (up_c2) begin
            up_mt = (mt == 4'd9) ? mt : mt + 4'd1;
        end else begin
            up_mt = mt;
        end
    end

    // Down-count ripple: a borrowing digit reloads its maximum and the borrow
    // moves on to the next digit only while the lower digit borrowed
    always_comb begin
        su_d  = dec_digit(su);
        st_d  = dec_digit(st);
        mu_d  = dec_digit(mu);
        mt_d  = dec_digit(mt);

        dn_b0 = ~su_d[4];
        dn_su = dn_b0 ? 4'd9 : su_d[3:0];

        dn_b1 = dn_b0 & ~st_d[4];
        if (dn_b0) begin
            dn_st = (~st_d[4]) ? 4'd5 : st_d[3:0];
        end else begin
            dn_st = st;
        end

        dn_b2 = dn_b1 & ~mu_d[4];
        if (dn_b1) begin
            dn_mu = (~mu_d[4]) ? 4'd9 : mu_d[3:0];
        end else begin
            dn_mu = mu;
        end

        if (dn_b2 && mt_d[4]) begin
            dn_mt = mt_d[3:0];
        end else begin
            dn_mt = mt;
        end
    end

    // Detect the terminal values 99:59 and 00:00, now and after one step
    always_comb begin
        at_max       = ({mt, mu, st, su} == 16'h9959);
        at_zero      = ({mt, mu, st, su} == 16'h0000);
        up_hits_max  = ({up_mt, up_mu, up_st, up_su} == 16'h9959);
        dn_hits_zero = ({dn_mt, dn_mu, dn_st, dn_su} == 16'h0000);
    end

    // Control FSM together with the digit registers and the done pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            mode_q <= 1'b0;
            su     <= 4'd0;
            st     <= 4'd0;
            mu     <= 4'd0;
            mt     <= 4'd0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load && (state != RUN)) begin
                su    <= ld_su;
                st    <= ld_st;
                mu    <= ld_mu;
                mt    <= ld_mt;
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !(mode && at_zero)) begin
                            state  <= RUN;
                            mode_q <= mode;
                        end
                    end
                    PAUSE: begin
                        if (start) begin
                            state <= RUN;
                        end
                    end
                    RUN: begin
                        if (tick) begin
                            if (!mode_q) begin
                                if (at_max) begin
                                    state <= EXPIRED;
                                    done  <= 1'b1;
                                end else begin
                                    su <= up_su;
                                    st <= up_st;
                                    mu <= up_mu;
                                    mt <= up_mt;
                                    if (up_hits_max) begin
                                        state <= EXPIRED;
                                        done  <= 1'b1;
                                    end else if (start) begin
                                        state <= PAUSE;
                                    end
                                end
                            end else begin
                                if (at_zero) begin
                                    state <= EXPIRED;
                                    done  <= 1'b1;
                                end else begin
                                    su <= dn_su;
                                    st <= dn_st;
                                    mu <= dn_mu;
                                    mt <= dn_mt;
                                    if (dn_hits_zero) begin
                                        state <= EXPIRED;
                                        done  <= 1'b1;
                                    end else if (start) begin
                                        state <= PAUSE;
                                    end
                                end
                            end
                        end else if (start) begin
                            state <= PAUSE;
                        end
                    end
                    EXPIRED: begin
                        state <= EXPIRED;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign min_bcd = {mt, mu};
    assign sec_bcd = {st, su};
    assign running = (state == RUN);

endmodule

// File: tb/tb_mm_ss_timer_counter.sv
// Testbench for mm_ss_timer_counter: directed scenarios with literal
// expectations, then randomized stimulus, all compared every cycle against a
// model that keeps the time as a plain number of seconds.

module tb_mm_ss_timer_counter;

    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_PAUSE = 2;
    localparam int S_EXP   = 3;
    localparam int MAX_SECS = 99 * 60 + 59;

    typedef struct {
        int state;
        int secs;
        bit lmode;
        bit done;
        bit valid;
    } model_t;

    logic       clk;
    logic       reset;
    logic       tick;
    logic       mode;
    logic       start;
    logic       load;
    logic [7:0] preset_min;
    logic [7:0] preset_sec;
    logic [7:0] min_bcd;
    logic [7:0] sec_bcd;
    logic       running;
    logic       done;

    int checks = 0;
    int errors = 0;

    model_t m = '{state: S_IDLE, secs: 0, lmode: 1'b0, done: 1'b0, valid: 1'b0};

    mm_ss_timer_counter dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .mode       (mode),
        .start      (start),
        .load       (load),
        .preset_min (preset_min),
        .preset_sec (preset_sec),
        .min_bcd    (min_bcd),
        .sec_bcd    (sec_bcd),
        .running    (running),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Preset converted to seconds after limiting each digit to its range
    function automatic int clamp_secs(input logic [7:0] pm, input logic [7:0] ps);
        int a;
        int b;
        int c;
        int d;
        a = int'(pm[7:4]);
        b = int'(pm[3:0]);
        c = int'(ps[7:4]);
        d = int'(ps[3:0]);
        if (a > 9) a = 9;
        if (b > 9) b = 9;
        if (c > 5) c = 5;
        if (d > 9) d = 9;
        return (a * 10 + b) * 60 + c * 10 + d;
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        logic [7:0] r;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    // Next model state from the behavioural rules, working in whole seconds
    function automatic model_t model_next(input model_t cur, input bit r, input bit tk,
                                          input bit stt, input bit ld, input bit md,
                                          input logic [7:0] pm, input logic [7:0] ps);
        model_t n;
        n = cur;
        n.done = 1'b0;
        if (r) begin
            n.state = S_IDLE;
            n.secs  = 0;
            n.lmode = 1'b0;
            n.valid = 1'b1;
            return n;
        end
        if (ld && cur.state != S_RUN) begin
            n.secs  = clamp_secs(pm, ps);
            n.state = S_IDLE;
        end else if (cur.state == S_IDLE) begin
            if (stt && !(md && cur.secs == 0)) begin
                n.state = S_RUN;
                n.lmode = md;
            end
        end else if (cur.state == S_PAUSE) begin
            if (stt) n.state = S_RUN;
        end else if (cur.state == S_RUN) begin
            if (tk) begin
                int target;
                target = cur.lmode ? 0 : MAX_SECS;
                if (cur.secs == target) begin
                    n.state = S_EXP;
                    n.done  = 1'b1;
                end else begin
                    n.secs = cur.lmode ? cur.secs - 1 : cur.secs + 1;
                    if (n.secs == target) begin
                        n.state = S_EXP;
                        n.done  = 1'b1;
                    end else if (stt) begin
                        n.state = S_PAUSE;
                    end
                end
            end else if (stt) begin
                n.state = S_PAUSE;
            end
        end
        return n;
    endfunction

    always @(posedge clk) begin
        m <= model_next(m, reset, tick, start, load, mode, preset_min, preset_sec);
    end

    task automatic compareSig(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every cycle after the first reset edge, the DUT must agree with the model
    always @(negedge clk) begin
        if (m.valid) begin
            compareSig("model_min", min_bcd, to_bcd(m.secs / 60));
            compareSig("model_sec", sec_bcd, to_bcd(m.secs % 60));
            compareSig("model_running", {7'd0, running}, {7'd0, (m.state == S_RUN)});
            compareSig("model_done", {7'd0, done}, {7'd0, m.done});
        end
    end

    // Drive one cycle of inputs, return at the following falling edge
    task automatic applyStimulus(input bit r, input bit tk, input bit stt, input bit ld,
                                 input bit md, input logic [7:0] pm, input logic [7:0] ps);
        reset      = r;
        tick       = tk;
        start      = stt;
        load       = ld;
        mode       = md;
        preset_min = pm;
        preset_sec = ps;
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [7:0] emin, input logic [7:0] esec,
                               input bit erun, input bit edone);
        compareSig({name, "_min"}, min_bcd, emin);
        compareSig({name, "_sec"}, sec_bcd, esec);
        compareSig({name, "_running"}, {7'd0, running}, {7'd0, erun});
        compareSig({name, "_done"}, {7'd0, done}, {7'd0, edone});
    endtask

    initial begin
        reset = 1'b1; tick = 1'b0; start = 1'b0; load = 1'b0; mode = 1'b0;
        preset_min = 8'h00; preset_sec = 8'h00;
        @(negedge clk);

        applyStimulus(1, 0, 0, 0, 0, 8'h00, 8'h00);
        applyStimulus(1, 0, 0, 0, 0, 8'h00, 8'h00);
        checkOutput("reset", 8'h00, 8'h00, 0, 0);

        // Countdown borrow chain
        applyStimulus(0, 0, 0, 1, 1, 8'h10, 8'h00);
        checkOutput("load_10_00", 8'h10, 8'h00, 0, 0);
        applyStimulus(0, 0, 1, 0, 1, 8'h00, 8'h00);
        checkOutput("start_down", 8'h10, 8'h00, 1, 0);
        applyStimulus(0, 1, 0, 0, 1, 8'h00, 8'h00);
        checkOutput("borrow_09_59", 8'h09, 8'h59, 1, 0);
        applyStimulus(0, 1, 0, 0, 1, 8'h00, 8'h00);
        checkOutput("down_09_58", 8'h09, 8'h58, 1, 0);

        // Countdown expiry
        applyStimulus(0, 0, 1, 0, 1, 8'h00, 8'h00);
        checkOutput("pause", 8'h09, 8'h58, 0, 0);
        applyStimulus(0, 0, 0, 1, 1, 8'h00, 8'h02);
        applyStimulus(0, 0, 1, 0, 1, 8'h00, 8'h00);
        applyStimulus(0, 1, 0, 0, 1, 8'h00, 8'h00);
        checkOutput("down_00_01", 8'h00, 8'h01, 1, 0);
        applyStimulus(0, 1, 0, 0, 1, 8'h00, 8'h00);
        checkOutput("expire_down", 8'h00, 8'h00, 0, 1);
        applyStimulus(0, 0, 0, 0, 1, 8'h00, 8'h00);
        checkOutput("done_drops", 8'h00, 8'h00, 0, 0);
        applyStimulus(0, 1, 0, 0, 1, 8'h00, 8'h00);
        checkOutput("expired_hold", 8'h00, 8'h00, 0, 0);

        // Up count wraps and up expiry
        applyStimulus(0, 0, 0, 1, 0, 8'h00, 8'h58);
        applyStimulus(0, 0, 1, 0, 0, 8'h00, 8'h00);
        applyStimulus(0, 1, 0, 0, 0, 8'h00, 8'h00);
        checkOutput("up_00_59", 8'h00, 8'h59, 1, 0);
        applyStimulus(0, 1, 0, 0, 0, 8'h00, 8'h00);
        checkOutput("up_01_00", 8'h01, 8'h00, 1, 0);
        applyStimulus(0, 0, 1, 0, 0, 8'h00, 8'h00);
        applyStimulus(0, 0, 0, 1, 0, 8'h99, 8'h58);
        applyStimulus(0, 0, 1, 0, 0, 8'h00, 8'h00);
        applyStimulus(0, 1, 0, 0, 0, 8'h00, 8'h00);
        checkOutput("expire_up", 8'h99, 8'h59, 0, 1);

        // Clamp, pause-with-tick, load ignored in RUN
        applyStimulus(0, 0, 0, 1, 0, 8'h7F, 8'h6A);
        checkOutput("clamp_79_59", 8'h79, 8'h59, 0, 0);
        applyStimulus(0, 0, 1, 0, 0, 8'h00, 8'h00);
        applyStimulus(0, 1, 0, 0, 0, 8'h00, 8'h00);
        checkOutput("up_80_00", 8'h80, 8'h00, 1, 0);
        applyStimulus(0, 1, 0, 0, 0, 8'h00, 8'h00);
        applyStimulus(0, 1, 1, 0, 0, 8'h00, 8'h00);
        checkOutput("tick_and_pause", 8'h80, 8'h02, 0, 0);
        applyStimulus(0, 0, 1, 0, 0, 8'h00, 8'h00);
        applyStimulus(0, 0, 0, 1, 0, 8'h12, 8'h34);
        checkOutput("load_in_run", 8'h80, 8'h02, 1, 0);
        applyStimulus(0, 0, 1, 0, 0, 8'h00, 8'h00);

        // Guard cases
        applyStimulus(0, 0, 0, 1, 1, 8'h00, 8'h00);
        applyStimulus(0, 0, 1, 0, 1, 8'h00, 8'h00);
        checkOutput("start_at_zero_down", 8'h00, 8'h00, 0, 0);
        applyStimulus(0, 0, 1, 1, 0, 8'h05, 8'h30);
        checkOutput("load_beats_start", 8'h05, 8'h30, 0, 0);
        applyStimulus(0, 0, 1, 0, 0, 8'h00, 8'h00);
        checkOutput("run_05_30", 8'h05, 8'h30, 1, 0);
        applyStimulus(1, 1, 1, 1, 0, 8'h44, 8'h44);
        checkOutput("reset_mid_run", 8'h00, 8'h00, 0, 0);

        // Randomized traffic, checked by the per-cycle model comparison
        for (int i = 0; i < 6000; i++) begin
            bit         r;
            bit         tk;
            bit         stt;
            bit         ld;
            bit         md;
            logic [7:0] pm;
            logic [7:0] ps;
            int         kind;
            r    = ($urandom_range(0, 399) == 0);
            tk   = ($urandom_range(0, 1) == 1);
            stt  = ($urandom_range(0, 7) == 0);
            ld   = ($urandom_range(0, 15) == 0);
            md   = ($urandom_range(0, 1) == 1);
            kind = $urandom_range(0, 3);
            case (kind)
                0: begin pm = 8'($urandom); ps = 8'($urandom); end
                1: begin pm = 8'h99; ps = 8'h50 | 8'($urandom_range(0, 9)); end
                2: begin pm = 8'h00; ps = 8'($urandom_range(0, 9)); end
                default: begin
                    pm = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
                    ps = {4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
                end
            endcase
            applyStimulus(r, tk, stt, ld, md, pm, ps);
        end

        applyStimulus(0, 0, 0, 0, 0, 8'h00, 8'h00);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
